// File: rtl/quad_move_ctrl.sv
// Closed-loop point-to-point move sequencer: quadrature decoder, two-speed PWM
// profile toward a latched target, deadband settle and completion pulse.
module quad_move_ctrl #(
    parameter int PWM_BITS      = 8,
    parameter int POS_BITS      = 24,
    parameter int FAST_DUTY     = 255,
    parameter int SLOW_DUTY     = 64,
    parameter int SLOW_ZONE     = 64,
    parameter int DEADBAND      = 2,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic signed [POS_BITS-1:0] CMD_TARGET,
    input  logic                       ABORT,
    input  logic                       POS_CLEAR,
    input  logic                       A,
    input  logic                       B,
    output logic                       F,
    output logic                       R,
    output logic signed [POS_BITS-1:0] POSITION,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       QERR
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE} state_t;
    typedef enum logic [1:0] {D_OFF, D_FWD, D_REV} dir_t;

    localparam logic [POS_BITS:0]   LP_DB          = (POS_BITS+1)'(DEADBAND);
    localparam logic [POS_BITS:0]   LP_SZ          = (POS_BITS+1)'(SLOW_ZONE);
    localparam logic [PWM_BITS-1:0] LP_FAST        = PWM_BITS'(FAST_DUTY);
    localparam logic [PWM_BITS-1:0] LP_SLOW        = PWM_BITS'(SLOW_DUTY);
    localparam logic [15:0]         LP_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    logic                       r_a_s1, r_a_s2, r_b_s1, r_b_s2;
    logic [1:0]                 r_ab_prev;
    logic signed [POS_BITS-1:0] r_pos;
    logic signed [POS_BITS-1:0] r_tgt;
    logic                       r_qerr;
    state_t                     r_state, w_state_next;
    logic [15:0]                r_settle_cnt, w_settle_next;
    logic                       r_done, w_done_next;
    logic [PWM_BITS-1:0]        r_pwm_cnt, r_duty, w_duty_new;
    dir_t                       r_dir, w_dir_req, w_dir_new;
    logic                       r_f, r_r;

    logic [1:0]                 w_idx_cur, w_idx_prev, w_delta;
    logic                       w_accept, w_busy, w_in_band, w_err_neg;
    logic signed [POS_BITS:0]   w_err;
    logic [POS_BITS:0]          w_err_abs;

    // Gray {B,A} -> binary phase index; the index difference gives the step.
    assign w_idx_cur  = {r_b_s2, r_b_s2 ^ r_a_s2};
    assign w_idx_prev = {r_ab_prev[1], r_ab_prev[1] ^ r_ab_prev[0]};
    assign w_delta    = w_idx_cur - w_idx_prev;

    assign w_busy    = (r_state == S_RUN) || (r_state == S_SETTLE);
    assign w_accept  = (r_state == S_IDLE) && CMD_VALID;
    assign w_err     = $signed({r_tgt[POS_BITS-1], r_tgt}) - $signed({r_pos[POS_BITS-1], r_pos});
    assign w_err_neg = w_err[POS_BITS];
    assign w_err_abs = w_err_neg ? (POS_BITS+1)'(-w_err) : (POS_BITS+1)'(w_err);
    assign w_in_band = (w_err_abs <= LP_DB);

    always_comb begin
        w_dir_req = D_OFF;
        if (w_busy && !w_in_band) begin
            w_dir_req = w_err_neg ? D_REV : D_FWD;
        end
        // A direct FWD<->REV flip is replaced by one OFF period.
        w_dir_new = w_dir_req;
        if ((w_dir_req != D_OFF) && (r_dir != D_OFF) && (w_dir_req != r_dir)) begin
            w_dir_new = D_OFF;
        end
        w_duty_new = (w_err_abs > LP_SZ) ? LP_FAST : LP_SLOW;
    end

    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle_cnt;
        w_done_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (CMD_VALID) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (ABORT) begin
                    w_state_next = S_IDLE;
                end else if (w_in_band) begin
                    w_state_next  = S_SETTLE;
                    w_settle_next = '0;
                end
            end
            S_SETTLE: begin
                if (ABORT) begin
                    w_state_next = S_IDLE;
                end else if (!w_in_band) begin
                    w_state_next = S_RUN;
                end else if (r_settle_cnt == LP_SETTLE_LAST) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_settle_next = r_settle_cnt + 16'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_a_s1       <= 1'b0;
            r_a_s2       <= 1'b0;
            r_b_s1       <= 1'b0;
            r_b_s2       <= 1'b0;
            r_ab_prev    <= '0;
            r_pos        <= '0;
            r_tgt        <= '0;
            r_qerr       <= 1'b0;
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_done       <= 1'b0;
            r_pwm_cnt    <= '0;
            r_duty       <= '0;
            r_dir        <= D_OFF;
            r_f          <= 1'b0;
            r_r          <= 1'b0;
        end else begin
            r_a_s1    <= A;
            r_a_s2    <= r_a_s1;
            r_b_s1    <= B;
            r_b_s2    <= r_b_s1;
            r_ab_prev <= {r_b_s2, r_a_s2};

            if ((r_state == S_IDLE) && POS_CLEAR) begin
                r_pos <= '0;
            end else if (w_delta == 2'd1) begin
                r_pos <= r_pos + POS_BITS'(1);
            end else if (w_delta == 2'd3) begin
                r_pos <= r_pos - POS_BITS'(1);
            end

            if (w_delta == 2'd2) begin
                r_qerr <= 1'b1;
            end else if (w_accept) begin
                r_qerr <= 1'b0;
            end

            if (w_accept) r_tgt <= CMD_TARGET;

            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
            r_done       <= w_done_next;
            r_pwm_cnt    <= r_pwm_cnt + PWM_BITS'(1);

            if (r_pwm_cnt == '1) r_duty <= w_duty_new;
            if (w_state_next == S_IDLE) begin
                r_dir <= D_OFF;
            end else if (r_pwm_cnt == '1) begin
                r_dir <= w_dir_new;
            end

            r_f <= (r_dir == D_FWD) && (r_pwm_cnt < r_duty);
            r_r <= (r_dir == D_REV) && (r_pwm_cnt < r_duty);
        end
    end

    assign CMD_READY = (r_state == S_IDLE);
    assign BUSY      = w_busy;
    assign DONE      = r_done;
    assign QERR      = r_qerr;
    assign POSITION  = r_pos;
    assign F         = r_f;
    assign R         = r_r;

endmodule

// File: tb/tb_quad_move_ctrl.sv
// Directed self-checking bench for quad_move_ctrl with a simple motor model
// that turns F/R drive time into encoder steps.
module tb_quad_move_ctrl;

    logic               CLOCK = 1'b0;
    logic               RESET = 1'b1;
    logic               CMD_VALID = 1'b0;
    logic               CMD_READY;
    logic signed [23:0] CMD_TARGET = '0;
    logic               ABORT = 1'b0;
    logic               POS_CLEAR = 1'b0;
    logic               A, B;
    logic               F, R;
    logic signed [23:0] POSITION;
    logic               BUSY, DONE, QERR;

    quad_move_ctrl #(
        .PWM_BITS(8), .POS_BITS(24), .FAST_DUTY(255), .SLOW_DUTY(64),
        .SLOW_ZONE(64), .DEADBAND(2), .SETTLE_CYCLES(1024)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TARGET(CMD_TARGET), .ABORT(ABORT), .POS_CLEAR(POS_CLEAR),
        .A(A), .B(B), .F(F), .R(R), .POSITION(POSITION),
        .BUSY(BUSY), .DONE(DONE), .QERR(QERR)
    );

    always #5 CLOCK = ~CLOCK;

    // Encoder position = motor shaft count + manual offset; phase maps to gray {B,A}.
    int         m_pos = 0;
    int         m_acc = 0;
    int         man_off = 0;
    bit         motor_on = 1'b0;
    logic [1:0] ph;
    assign ph = 2'(m_pos + man_off);
    assign A  = (ph == 2'd1) || (ph == 2'd2);
    assign B  = ph[1];

    always @(negedge CLOCK) begin
        if (motor_on) begin
            if (F === 1'b1 && R === 1'b0) m_acc++;
            else if (R === 1'b1 && F === 1'b0) m_acc--;
            if (m_acc >= 16) begin m_pos++; m_acc = 0; end
            else if (m_acc <= -16) begin m_pos--; m_acc = 0; end
        end
    end

    // Independent period phase: equals the PWM counter value at each sample point.
    logic [7:0] pc = '0;
    always @(posedge CLOCK) begin
        if (RESET) pc <= '0;
        else       pc <= pc + 8'd1;
    end

    int checks = 0, passes = 0, fails = 0;
    int overlap = 0, done_cnt = 0;
    bit track = 1'b0, saw_fast = 1'b0, saw_slow = 1'b0;
    int highs = 0, cur_err = 0, next_err = 0, prof_bad = 0;
    int track_tgt = 0;

    function automatic int posi();
        return int'(POSITION);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
        if (F === 1'b1 && R === 1'b1) overlap++;
        if (DONE === 1'b1) done_cnt++;
        if (track) begin
            if (pc == 8'd255) next_err = track_tgt - posi();
            if (F === 1'b1) highs++;
            if (pc == 8'd0) begin
                if (highs == 255) begin
                    saw_fast = 1'b1;
                    if (!(cur_err > 64)) prof_bad++;
                end
                if (highs == 64) begin
                    saw_slow = 1'b1;
                    if (!(cur_err > 2 && cur_err <= 64)) prof_bad++;
                end
                highs   = 0;
                cur_err = next_err;
            end
        end
    endtask

    task automatic enc_to(input int v);
        man_off = v;
        repeat (3) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  waited, zeros, fh, p, dsnap, err;
        bit  got_done;

        // Reset with encoder activity and a command that must be ignored.
        CMD_VALID  = 1'b1;
        CMD_TARGET = 24'sd500;
        man_off = 1; tick();
        man_off = 3; tick();
        man_off = 2; tick();
        chk("ready_in_reset", int'(CMD_READY), 1);
        chk("busy_in_reset", int'(BUSY), 0);
        RESET = 1'b0; CMD_VALID = 1'b0; man_off = 0;
        tick();
        chk("rst_pos", posi(), 0);
        chk("rst_f", int'(F), 0);
        chk("rst_r", int'(R), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_qerr", int'(QERR), 0);
        chk("rst_ready", int'(CMD_READY), 1);
        chk("rst_done", int'(DONE), 0);

        // Decoder forward sequence with latency check, then reverse.
        man_off = 1; tick(); tick();
        chk("dec_latency2", posi(), 0);
        tick();
        chk("dec_latency3", posi(), 1);
        enc_to(2); enc_to(3); enc_to(4);
        chk("dec_fwd4", posi(), 4);
        enc_to(3); enc_to(2); enc_to(1); enc_to(0);
        chk("dec_rev0", posi(), 0);
        chk("dec_no_qerr", int'(QERR), 0);
        enc_to(2);
        chk("dec_qerr_set", int'(QERR), 1);
        chk("dec_double_hold", posi(), 0);
        man_off = 1; tick(); tick();
        POS_CLEAR = 1'b1; tick(); POS_CLEAR = 1'b0;
        chk("dec_clear_prio", posi(), 0);
        enc_to(0);
        chk("dec_wrap_neg1", posi(), -1);
        POS_CLEAR = 1'b1; tick(); POS_CLEAR = 1'b0;
        chk("dec_clear_idle", posi(), 0);
        chk("qerr_sticky", int'(QERR), 1);

        // Long closed-loop move to +1000.
        motor_on = 1'b1;
        track_tgt = 1000;
        overlap = 0; done_cnt = 0;
        CMD_TARGET = 24'sd1000; CMD_VALID = 1'b1;
        track = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        chk("long_busy", int'(BUSY), 1);
        chk("long_ready_low", int'(CMD_READY), 0);
        chk("long_qerr_cleared", int'(QERR), 0);
        got_done = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            tick();
            if (DONE === 1'b1) begin got_done = 1'b1; break; end
        end
        chk("long_done_seen", int'(got_done), 1);
        chk("long_ready_with_done", int'(CMD_READY), 1);
        err = 1000 - posi();
        chk("long_final_inband", int'(err <= 2 && err >= -2), 1);
        repeat (300) tick();
        track = 1'b0;
        motor_on = 1'b0;
        chk("long_done_once", done_cnt, 1);
        chk("long_saw_fast", int'(saw_fast), 1);
        chk("long_saw_slow", int'(saw_slow), 1);
        chk("long_profile", prof_bad, 0);
        chk("long_idle", int'(BUSY), 0);

        // Reversal: start forward, then push the encoder 20 past target.
        p = posi();
        CMD_TARGET = 24'(p + 30); CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        waited = 0;
        while (F !== 1'b1 && waited < 400) begin tick(); waited++; end
        chk("rev_f_start", int'(F), 1);
        chk("rev_f_latency", int'(waited <= 257), 1);
        for (int i = 0; i < 50; i++) begin
            man_off = man_off + 1;
            tick(); tick();
        end
        waited = 0;
        while (pc != 8'd0 && waited < 300) begin tick(); waited++; end
        zeros = 0; fh = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (R === 1'b1) break;
            zeros++;
            if (F === 1'b1) fh++;
        end
        chk("rev_r_asserted", int'(R), 1);
        chk("rev_dead_period", zeros, 256);
        chk("rev_no_f", fh, 0);

        // Position clear while busy, then abort mid-period.
        repeat (10) tick();
        chk("abort_r_active", int'(R), 1);
        p = posi();
        POS_CLEAR = 1'b1; tick(); POS_CLEAR = 1'b0;
        chk("clear_busy_ignored", posi(), p);
        dsnap = done_cnt;
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        chk("abort_busy_k", int'(BUSY), 0);
        chk("abort_ready_k", int'(CMD_READY), 1);
        tick();
        chk("abort_f", int'(F), 0);
        chk("abort_r", int'(R), 0);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_no_done", done_cnt, dsnap);

        // New command at current position, then a settle disturbance.
        CMD_TARGET = 24'(posi()); CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        chk("newcmd_busy", int'(BUSY), 1);
        chk("newcmd_ready_low", int'(CMD_READY), 0);
        repeat (500) tick();
        chk("settle_busy", int'(BUSY), 1);
        for (int i = 0; i < 5; i++) begin man_off = man_off + 1; tick(); tick(); end
        for (int i = 0; i < 2; i++) begin man_off = man_off - 1; tick(); tick(); end
        man_off = man_off - 1;
        repeat (1027) tick();
        chk("settle_no_early_done", done_cnt, dsnap);
        chk("settle_done_low", int'(DONE), 0);
        chk("settle_still_busy", int'(BUSY), 1);
        tick();
        chk("settle_done_pulse", int'(DONE), 1);
        chk("settle_ready", int'(CMD_READY), 1);
        tick();
        chk("settle_done_once", int'(DONE), 0);
        chk("settle_idle", int'(BUSY), 0);
        chk("no_f_r_overlap", overlap, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/quad_move_ctrl.md
# quad_move_ctrl

Closed-loop point-to-point move sequencer for one DC motor with a quadrature encoder. It accepts a target position over a valid/ready handshake and decodes encoder A/B into a signed position count. It drives the H-bridge forward/reverse PWM pins (F, R) with a two-speed profile until the position holds inside a deadband for a settle time, then reports completion. It sits between the CPU-side register interface and the bridge/encoder pins; in simulation it closes the loop around the motor simulator.

## Interface
- PWM_BITS, 8: PWM counter width; period = 2^PWM_BITS cycles
- POS_BITS, 24: position and target width, signed two's complement
- FAST_DUTY, 255: duty used when |error| > SLOW_ZONE
- SLOW_DUTY, 64: duty used when DEADBAND < |error| <= SLOW_ZONE
- SLOW_ZONE, 64: distance in counts where the move switches to slow duty
- DEADBAND, 2: |error| <= DEADBAND counts as on target
- SETTLE_CYCLES, 1024: cycles the position must stay in the deadband before DONE (16-bit counter)
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CMD_VALID  in  1  target present
- CMD_READY  out  1  block can accept a target; high exactly when state is IDLE
- CMD_TARGET  in  POS_BITS  signed target position
- ABORT  in  1  cancel the move in progress
- POS_CLEAR  in  1  zero the position counter; honoured only in IDLE
- A, B  in  1  encoder inputs, asynchronous
- F, R  out  1  bridge forward/reverse PWM, registered, never both 1
- POSITION  out  POS_BITS  signed decoded position
- BUSY  out  1  state is RUN or SETTLE
- DONE  out  1  one-cycle pulse on successful completion
- QERR  out  1  sticky illegal-transition flag; cleared by RESET or an accepted command

## Operation
- Reset values: state IDLE, POSITION 0, F=R=0, DONE=0, QERR=0, PWM counter 0, latched direction OFF, target 0. CMD_READY reads 1 during reset, but commands are ignored while RESET=1.
- Decoder: A/B pass through a 2-flop synchronizer. {B,A} forward sequence is 00→01→11→10→00, and each forward step adds +1. The reverse sequence subtracts 1. A double-bit change leaves the count unchanged and sets QERR. POSITION wraps modulo 2^POS_BITS. POS_CLEAR in IDLE has priority over a same-cycle step.
- error = CMD_TARGET_latched − POSITION, evaluated at POS_BITS+1 bits signed. This is the true difference; there is no shortest-path wrap handling.
- FSM:
  - IDLE: F=R=0. CMD_VALID && CMD_READY latches the target, clears QERR, and moves to RUN.
  - RUN: motor is driven. When |error| <= DEADBAND, go to SETTLE and clear the settle counter.
  - SETTLE: the motor is still driven by error. If |error| > DEADBAND, return to RUN. When the settle counter reaches SETTLE_CYCLES−1, go to IDLE and pulse DONE.
  - ABORT in RUN or SETTLE: go to IDLE without DONE. ABORT has priority over the completion transition in the same cycle. ABORT in IDLE is ignored.
- PWM: a free-running counter runs in all states. At the period boundary (counter = all-ones), the block latches duty and direction for the next period:
  - dir is FWD if error > DEADBAND, REV if error < −DEADBAND, otherwise OFF; it is forced OFF unless state is RUN or SETTLE.
  - Reversal dead period: if the new dir is the opposite of the currently latched non-OFF dir, the block latches OFF for one period.
  - duty is FAST_DUTY if |error| > SLOW_ZONE, otherwise SLOW_DUTY.
- Output: F <= (dir==FWD) && (cnt < duty), and R is symmetric. Entering IDLE (done, abort, or reset) forces the latched dir to OFF immediately.

## Timing
- Command accepted at edge k: BUSY=1 and CMD_READY=0 after edge k. F/R first assert in the cycle after the next period-boundary latch, i.e. within 2^PWM_BITS+1 cycles.
- Encoder edge to POSITION update: 3 cycles (2 synchronizer cycles + 1 count register).
- DONE: asserts for the one cycle after the transition to IDLE. CMD_READY=1 in that same cycle, so a new command is accepted back-to-back.
- ABORT sampled at edge k: F=R=0 and BUSY=0 after edge k+1.
- Duty and direction never change mid-period, except for the forced OFF on entering IDLE.

## Test plan
- Reset: hold RESET 3 cycles with A/B toggling → POSITION=0, F=R=0, BUSY=0, QERR=0, CMD_READY=1.
- Decoder: {B,A} sequence 00,01,11,10,00 → POSITION=4. Reverse sequence → back to 0. Apply 00→11 → QERR=1 and POSITION unchanged. POS_CLEAR while BUSY → ignored.
- Long move: closed loop with the motor simulator, target +1000 → FAST_DUTY until |error| <= 64, then SLOW_DUTY. Final |error| <= 2, DONE pulses exactly once, F&R never 1.
- Reversal: force error sign change from FWD (overshoot target −20) → exactly one full period of F=R=0 before R asserts.
- Abort: ABORT in RUN mid-period → F=R=0 and BUSY=0 two cycles later, no DONE. New command accepted on the next cycle.
- Settle disturbance: in SETTLE, step the encoder 5 counts away → returns to RUN, the settle counter restarts, and DONE only follows 1024 continuous in-band cycles.
